// File: rtl/noc_packet_buffer.sv
// noc_packet_buffer: single-clock AXI-Stream packet buffer for the tile NoC egress path.
// Release mode is set by STORE_FWD (1 = store-and-forward, 0 = cut-through).
// Optional macro NOC_BUF_DEADLOCK_RELEASE_EN: in store-and-forward mode, a packet that fills
// the whole buffer without its TLAST is released cut-through instead of stalling forever.
module noc_packet_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned KEEP_W    = DATA_W / 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned STORE_FWD = 1
) (
  input  logic              clk_in,
  input  logic              clk_in_rst_high,
  input  logic              stream_in_TVALID,
  input  logic [DATA_W-1:0] stream_in_TDATA,
  input  logic [KEEP_W-1:0] stream_in_TKEEP,
  input  logic              stream_in_TLAST,
  output logic              stream_in_TREADY,
  output logic              stream_out_TVALID,
  output logic [DATA_W-1:0] stream_out_TDATA,
  output logic [KEEP_W-1:0] stream_out_TKEEP,
  output logic              stream_out_TLAST,
  input  logic              stream_out_TREADY,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   pkt_count
);

  localparam int unsigned    DEPTH     = 1 << ADDR_W;
  localparam int unsigned    WORD_W    = 1 + KEEP_W + DATA_W;
  localparam logic [ADDR_W:0] FullLevel = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PtrOne    = {{ADDR_W{1'b0}}, 1'b1};

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q, pkt_count_q;
  logic              full, empty, push, pop, release_en;

  // Occupancy derives from the wrap-bit pointers, so full and empty need no extra flag.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == FullLevel);
  assign empty     = (level == '0);
  assign pkt_count = pkt_count_q;

  assign stream_in_TREADY = ~full & ~clk_in_rst_high;
  assign push = stream_in_TVALID & stream_in_TREADY;
  assign pop  = stream_out_TVALID & stream_out_TREADY;

  // Show-ahead read of the head word.
  assign {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA} = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Head word is offered once any complete packet is stored, or always in cut-through.
  always_comb begin
    if (STORE_FWD != 0) begin
      stream_out_TVALID = ~empty & ((pkt_count_q != '0) | release_en);
    end else begin
      stream_out_TVALID = ~empty;
    end
  end

`ifdef NOC_BUF_DEADLOCK_RELEASE_EN
  typedef enum logic {StIdle, StRelease} state_e;
  state_e state_q, state_d;

  // Full with no complete packet means one oversized packet owns the buffer: drain it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if ((STORE_FWD != 0) && full && (pkt_count_q == '0)) state_d = StRelease;
      end
      StRelease: begin
        if (pop && stream_out_TLAST) state_d = StIdle;
      end
    endcase
  end

  // Release state register.
  always_ff @(posedge clk_in) begin
    if (clk_in_rst_high) state_q <= StIdle;
    else                 state_q <= state_d;
  end

  assign release_en = (state_q == StRelease);
`else
  assign release_en = 1'b0;
`endif

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
  end

  // Pointers and complete-packet counter.
  always_ff @(posedge clk_in) begin
    if (clk_in_rst_high) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push & stream_in_TLAST, pop & stream_out_TLAST})
        2'b10:   pkt_count_q <= pkt_count_q + PtrOne;
        2'b01:   pkt_count_q <= pkt_count_q - PtrOne;
        default: pkt_count_q <= pkt_count_q;
      endcase
    end
  end

endmodule

// File: doc/noc_packet_buffer.md
# noc_packet_buffer

Single-clock, parametrised AXI-Stream packet buffer for the tile NoC egress path. It generalises the tile's output packet buffer in three ways: configurable data width and depth, selectable store-and-forward or cut-through release, and exported occupancy and packet-count status. Placed between a tile-side stream producer and the NoC router port where no clock crossing is required.

## Interface
Parameters:
- DATA_W, 32, stream data width in bits; must be a multiple of 8.
- KEEP_W, DATA_W/8, TKEEP width.
- ADDR_W, 4, log2 of buffer depth; DEPTH = 2^ADDR_W words.
- STORE_FWD, 1, 1 = a packet is released only after its TLAST word is stored; 0 = cut-through.

Ports:
- clk_in  in  1  single clock; all logic on rising edge.
- clk_in_rst_high  in  1  synchronous, active-high reset.
- stream_in_TVALID  in  1  input word valid.
- stream_in_TDATA  in  DATA_W  input data.
- stream_in_TKEEP  in  KEEP_W  input byte enables.
- stream_in_TLAST  in  1  last word of packet.
- stream_in_TREADY  out  1  buffer can accept.
- stream_out_TVALID  out  1  output word valid.
- stream_out_TDATA  out  DATA_W  output data.
- stream_out_TKEEP  out  KEEP_W  output byte enables.
- stream_out_TLAST  out  1  last word of packet.
- stream_out_TREADY  in  1  downstream accepts.
- level  out  ADDR_W+1  words currently stored, 0..DEPTH.
- pkt_count  out  ADDR_W+1  complete packets (TLAST stored) not yet fully drained.

## Operation
- Storage: DEPTH x (1+KEEP_W+DATA_W) register array holding {last, keep, data}. wr_ptr and rd_ptr are ADDR_W+1 bits wide; the MSB is the wrap bit. level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1). full = (level == DEPTH). empty = (level == 0).
- Push: push = stream_in_TVALID & stream_in_TREADY. stream_in_TREADY = ~full & ~clk_in_rst_high. When full, a word popped in the same cycle does not enable a push; the freed slot becomes visible on the next cycle.
- Pop: pop = stream_out_TVALID & stream_out_TREADY. Output fields are read directly from mem[rd_ptr] (show-ahead).
- pkt_count: +1 on a push with TLAST, -1 on a pop with TLAST; unchanged when both occur in the same cycle.
- Output valid:
  - STORE_FWD=0: stream_out_TVALID = ~empty.
  - STORE_FWD=1: stream_out_TVALID = ~empty & ((pkt_count != 0) | state == RELEASE).
- Once TVALID is asserted it is held until the word is accepted. This holds by construction, because pkt_count only falls on a TLAST pop.
- FSM, active only when STORE_FWD=1 with NOC_BUF_DEADLOCK_RELEASE_EN defined:
  - States: IDLE and RELEASE.
  - IDLE -> RELEASE when full & pkt_count == 0, i.e. an oversized packet has filled the buffer.
  - RELEASE -> IDLE on a pop with TLAST.
  - In RELEASE the packet drains cut-through.

## Timing
- Reset: all of the following clear in the cycle after clk_in_rst_high is sampled high.
  - Cleared state: pointers, pkt_count, FSM state = IDLE.
  - Output values: stream_out_TVALID=0, level=0, pkt_count=0, stream_in_TREADY=0 while reset is high and 1 after.
  - Memory contents are not reset. TDATA, TKEEP and TLAST are don't-care while TVALID=0.
- Reset mid-packet discards partial packets. Downstream may see TVALID drop; this is accepted.
- Latency, cut-through: a word pushed on edge N is valid on the output in the cycle after edge N (1 cycle).
- Latency, store-and-forward: the first word is valid in the cycle after the edge at which TLAST is pushed.
- level and pkt_count are registered-derived and reflect pushes and pops of the previous edge.
- Sustained throughput is 1 word/cycle when neither full nor empty. Pointer wrap at DEPTH is seamless.

## Configuration
- NOC_BUF_DEADLOCK_RELEASE_EN defined:
  - The FSM above is compiled in.
  - A packet longer than DEPTH in store-and-forward mode degrades to cut-through for that packet only.
- Not defined:
  - No FSM; stream_out_TVALID depends only on pkt_count.
  - An oversized packet stalls the buffer permanently: level=DEPTH, pkt_count=0, TREADY=0.
  - Upstream must never send packets longer than DEPTH.

## Test plan
- Reset with STORE_FWD=1, then push a 3-word packet (TLAST on word 3) with TREADY_out=0 -> TVALID_out stays 0 until the cycle after word 3; then level=3, pkt_count=1.
- STORE_FWD=0, push 1 word with TREADY_out=1 -> TVALID_out=1 the next cycle; word popped; level returns to 0.
- ADDR_W=4, push 16 words with no pops -> level=16, stream_in_TREADY=0. Pop 1 -> TREADY=1 one cycle later. Data order preserved across pointer wrap after 40 words streamed.
- Simultaneous push of a TLAST word and pop of a TLAST word with pkt_count=2 -> pkt_count stays 2 and level is unchanged.
- Oversized packet, STORE_FWD=1:
  - Send a 20-word packet into DEPTH=16 with the macro defined -> enters RELEASE at level=16, all 20 words are delivered in order, FSM returns to IDLE after TLAST.
  - Without the macro -> stall with level=16, pkt_count=0.
- Assert reset mid-packet with level=5 -> next cycle level=0, pkt_count=0, TVALID_out=0. A subsequent packet is delivered intact.
